// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the iterative non-restoring divider: FSM state encoding and default width.
package nonrestoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nrdiv_step.sv
// One unsigned non-restoring division step: shift {P,A} left, then add or subtract D
// depending on the sign of the shifted partial remainder; the new quotient bit enters A[0].
module nrdiv_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH+1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH+1:0] d,
    output logic [WIDTH+1:0] p_next,
    output logic [WIDTH-1:0] a_next
);

    logic [WIDTH+1:0] p_shift;

    always_comb begin
        p_shift = (p << 1) | {{(WIDTH+1){1'b0}}, a[WIDTH-1]};
        // |P| < 2D always holds, so the shift never disturbs the sign bit
        p_next  = p_shift[WIDTH+1] ? (p_shift + d) : (p_shift - d);
        a_next  = {a[WIDTH-2:0], ~p_next[WIDTH+1]};
    end

endmodule

// File: rtl/nonrestoring_divider.sv
// Signed truncating divider: start-edge launch, WIDTH non-restoring steps on magnitudes,
// then a fix-up cycle that restores the remainder and applies the operand signs.
module nonrestoring_divider
    import nonrestoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e state_reg, state_next;

    logic             d1_reg, d2_reg;
    logic             edge_start;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH+1:0] p_reg, d_reg;
    logic [WIDTH-1:0] a_reg, dvd_reg;
    logic             neg_dvd_reg, neg_dvs_reg, zero_reg, ovf_case_reg;

    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             busy_reg, done_reg, div_zero_reg, ovf_reg;

    logic [WIDTH+1:0] step_p;
    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH+1:0] p_fix, r_full;
    logic [WIDTH-1:0] q_signed;

    assign edge_start = d1_reg & ~d2_reg;

    nrdiv_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .a      (a_reg),
        .d      (d_reg),
        .p_next (step_p),
        .a_next (step_a)
    );

    // A WIDTH-bit unsigned magnitude already holds |min| = 2^(WIDTH-1)
    always_comb begin
        abs_dvd  = dividend[WIDTH-1] ? -dividend : dividend;
        abs_dvs  = divisor[WIDTH-1]  ? -divisor  : divisor;
        p_fix    = p_reg[WIDTH+1] ? (p_reg + d_reg) : p_reg;
        r_full   = neg_dvd_reg ? -p_fix : p_fix;
        q_signed = (neg_dvd_reg ^ neg_dvs_reg) ? -a_reg : a_reg;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (edge_start) state_next = ITER;
            ITER: if (cnt_reg == CW'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            d1_reg        <= 1'b0;
            d2_reg        <= 1'b0;
            cnt_reg       <= '0;
            p_reg         <= '0;
            d_reg         <= '0;
            a_reg         <= '0;
            dvd_reg       <= '0;
            neg_dvd_reg   <= 1'b0;
            neg_dvs_reg   <= 1'b0;
            zero_reg      <= 1'b0;
            ovf_case_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            d1_reg    <= start;
            d2_reg    <= d1_reg;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: if (edge_start) begin
                    p_reg        <= '0;
                    a_reg        <= abs_dvd;
                    d_reg        <= {2'b00, abs_dvs};
                    dvd_reg      <= dividend;
                    neg_dvd_reg  <= dividend[WIDTH-1];
                    neg_dvs_reg  <= divisor[WIDTH-1];
                    zero_reg     <= (divisor == '0);
                    ovf_case_reg <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
                    cnt_reg      <= CW'(WIDTH);
                    busy_reg     <= 1'b1;
                    div_zero_reg <= 1'b0;
                    ovf_reg      <= 1'b0;
                end
                ITER: begin
                    p_reg   <= step_p;
                    a_reg   <= step_a;
                    cnt_reg <= cnt_reg - CW'(1);
                end
                FIX: begin
                    // Truncation to WIDTH bits happens only here; min / -1 wraps naturally
                    quotient_reg  <= zero_reg ? '1 : q_signed;
                    remainder_reg <= zero_reg ? dvd_reg : WIDTH'(r_full);
                    div_zero_reg  <= zero_reg;
                    ovf_reg       <= ovf_case_reg;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign div_zero  = div_zero_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: stimulus pushes expected results computed with
// integer division; a negedge monitor pops and compares whenever done is seen.
module tb_nonrestoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_zero, ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_txn    = 0;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           due;
    } exp_t;

    exp_t sb[$];

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed integer division, truncated to W bits afterwards
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
        exp_t e;
        int a, b, qi, ri;
        a = int'($signed(x));
        b = int'($signed(y));
        e.dvd = x;
        e.dvs = y;
        e.due = due;
        if (b == 0) begin
            e.q  = '1;
            e.r  = x;
            e.dz = 1'b1;
            e.ov = 1'b0;
        end else begin
            qi   = a / b;
            ri   = a % b;
            e.q  = W'(qi);
            e.r  = W'(ri);
            e.dz = 1'b0;
            e.ov = (qi > (2 ** (W - 1)) - 1);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: %0d / %0d -> q=%0d r=%0d dz=%0d ovf=%0d (exp q=%0d r=%0d dz=%0d ovf=%0d)",
                         n_txn, $signed(e.dvd), $signed(e.dvs), $signed(quotient), $signed(remainder),
                         div_zero, ovf, $signed(e.q), $signed(e.r), e.dz, e.ov);
                chk("quotient",  int'(quotient),  int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_zero",  int'(div_zero),  int'(e.dz));
                chk("ovf",       int'(ovf),       int'(e.ov));
                chk("busy_at_done", int'(busy), 0);
                chk("done_latency", cyc, e.due);
            end
        end
        if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("done_timeout", cyc, sb[0].due);
            void'(sb.pop_front());
        end
    end

    // Launch one division; start stays high 'hold' cycles, optional second edge during ITER
    task automatic run_div(input logic [W-1:0] x, input logic [W-1:0] y, input int hold,
                           input bit expect_result, input bit glitch);
        int k;
        @(negedge clk);
        dividend = x;
        divisor  = y;
        start    = 1'b1;
        k        = cyc;
        if (expect_result) sb.push_back(model(x, y, k + W + 3));
        repeat (2) @(negedge clk);
        chk("busy_after_load", int'(busy), 1);
        for (int i = 2; i < hold; i++) @(negedge clk);
        start = 1'b0;
        if (glitch) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < k + W + 5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_quotient",  int'(quotient),  0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_busy",      int'(busy),      0);
        chk("reset_done",      int'(done),      0);
        chk("reset_flags",     int'({div_zero, ovf}), 0);
        // start already high during reset: exactly one launch after release
        rst = 1'b0;
        sb.push_back(model(4'd0, 4'd0, cyc + W + 3));
        while (cyc < 20) @(negedge clk);
        start = 1'b0;

        run_div(4'd7,  4'd2,  2, 1'b1, 1'b0);
        run_div(-4'sd7, 4'd2, 2, 1'b1, 1'b0);
        run_div(4'd7, -4'sd2, 2, 1'b1, 1'b0);
        run_div(-4'sd8, -4'sd1, 2, 1'b1, 1'b0);
        run_div(-4'sd8, 4'd3, 2, 1'b1, 1'b0);
        run_div(4'd5,  4'd0,  2, 1'b1, 1'b0);
        run_div(4'd6,  4'd3,  2, 1'b1, 1'b0);
        run_div(4'd3,  4'd1, 12, 1'b1, 1'b0);
        run_div(4'd7,  4'd2,  2, 1'b1, 1'b1);

        // Reset during ITER: outputs cleared at the next edge and no done follows
        @(negedge clk);
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        k        = cyc;
        while (cyc < k + 4) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        chk("midreset_quotient",  int'(quotient),  0);
        chk("midreset_remainder", int'(remainder), 0);
        chk("midreset_busy",      int'(busy),      0);
        chk("midreset_flags",     int'({done, div_zero, ovf}), 0);
        rst = 1'b0;
        repeat (W + 6) @(negedge clk);
        run_div(4'd7, 4'd2, 2, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++)
            run_div(W'($urandom), W'($urandom), $urandom_range(2, 5), 1'b1, 1'b0);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
